// File: rtl/key_step_ctrl_if.sv
// Board-side bundle for key_step_ctrl: raw pushbuttons and switch in,
// debounced levels, edge pulses and the single-step request out.
interface key_step_ctrl_if;
  logic [3:0]  KEY;
  logic        manual_sw;
  logic [3:0]  key_level;
  logic [3:0]  key_press;
  logic [3:0]  key_release;
  logic        manual_mode;
  logic        step_pulse;
  logic [15:0] step_count;

  modport master (
    output KEY, manual_sw,
    input  key_level, key_press, key_release, manual_mode, step_pulse, step_count
  );

  modport slave (
    input  KEY, manual_sw,
    output key_level, key_press, key_release, manual_mode, step_pulse, step_count
  );
endinterface

// File: rtl/key_step_ctrl.sv
// Four-key debouncer with press/release pulses, plus a single-step request
// on KEY[3] gated by a synchronized manual-mode switch.

module key_deb_lane #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rls,
  output logic press_nxt
);
  localparam logic [19:0] CNT_LAST = 20'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED       = 2'd0,
    ARMING_PRESS   = 2'd1,
    PRESSED        = 2'd2,
    ARMING_RELEASE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s1_d, s2_q, s2_d;
  logic [19:0] cnt_q, cnt_d;
  logic        press_q, press_d, rls_q, rls_d;
  logic        hit;

  assign hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RELEASED;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rls_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rls_q   <= rls_d;
    end
  end

  // cnt runs only while the synchronized key disagrees with the accepted level
  always_comb begin
    s1_d    = ~key_n;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      RELEASED: begin
        if (s2_q) begin
          state_d = ARMING_PRESS;
          cnt_d   = cnt_q + 20'd1;
        end
      end
      ARMING_PRESS: begin
        if (!s2_q)    state_d = RELEASED;
        else if (hit) state_d = PRESSED;
        else          cnt_d   = cnt_q + 20'd1;
      end
      PRESSED: begin
        if (!s2_q) begin
          state_d = ARMING_RELEASE;
          cnt_d   = cnt_q + 20'd1;
        end
      end
      ARMING_RELEASE: begin
        if (s2_q)     state_d = PRESSED;
        else if (hit) state_d = RELEASED;
        else          cnt_d   = cnt_q + 20'd1;
      end
      default: state_d = RELEASED;
    endcase
  end

  always_comb begin
    level     = (state_q == PRESSED) || (state_q == ARMING_RELEASE);
    press_d   = (state_q == ARMING_PRESS) && s2_q && hit;
    rls_d     = (state_q == ARMING_RELEASE) && !s2_q && hit;
    press     = press_q;
    rls       = rls_q;
    press_nxt = press_d;
  end
endmodule

module key_step_ctrl #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  key_step_ctrl_if.slave io
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] level, press, rls, press_nxt;
  logic                 sw1_q, sw1_d, sw2_q, sw2_d;
  logic                 step_pulse_q, step_pulse_d;
  logic [15:0]          step_count_q, step_count_d;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    key_deb_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clk       (CLOCK_50),
      .rst       (reset),
      .key_n     (io.KEY[i]),
      .level     (level[i]),
      .press     (press[i]),
      .rls       (rls[i]),
      .press_nxt (press_nxt[i])
    );
  end

  // step pulse is built from next-state values so it lands with key_press[3]
  always_comb begin
    sw1_d        = io.manual_sw;
    sw2_d        = sw1_q;
    step_pulse_d = press_nxt[3] & sw2_d;
    step_count_d = step_count_q + 16'(step_pulse_d);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sw1_q        <= 1'b0;
      sw2_q        <= 1'b0;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      sw1_q        <= sw1_d;
      sw2_q        <= sw2_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

  assign io.key_level   = level;
  assign io.key_press   = press;
  assign io.key_release = rls;
  assign io.manual_mode = sw2_q;
  assign io.step_pulse  = step_pulse_q;
  assign io.step_count  = step_count_q;
endmodule

// File: tb/tb_key_step_ctrl.sv
// Directed bench for key_step_ctrl at DEB_CYCLES=4: a vector table for the
// per-cycle latency/pulse behaviour plus sequences for glitch, step, wrap, reset.
module tb_key_step_ctrl;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  key_step_ctrl_if io ();

  key_step_ctrl #(.DEB_CYCLES(DEB)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .io       (io)
  );

  always #5 clk = ~clk;

  // pulse tallies, sampled away from the active edge
  int mon_step = 0, mon_p3 = 0, mon_r3 = 0, mon_p1 = 0, mon_r1 = 0;
  always @(negedge clk) begin
    if (io.step_pulse === 1'b1)     mon_step = mon_step + 1;
    if (io.key_press[3] === 1'b1)   mon_p3   = mon_p3 + 1;
    if (io.key_release[3] === 1'b1) mon_r3   = mon_r3 + 1;
    if (io.key_press[1] === 1'b1)   mon_p1   = mon_p1 + 1;
    if (io.key_release[1] === 1'b1) mon_r1   = mon_r1 + 1;
  end

  typedef struct {
    logic        rst;
    logic [3:0]  key;
    logic        sw;
    int          cyc;
    logic [3:0]  lvl;
    logic [3:0]  pr;
    logic [3:0]  rl;
    logic        sp;
    logic        md;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] outs();
    return {io.key_level, io.key_press, io.key_release, io.step_pulse, io.manual_mode, io.step_count};
  endfunction

  function automatic void add(input logic r, input logic [3:0] k, input logic s, input int c,
                              input logic [3:0] l, input logic [3:0] p, input logic [3:0] q,
                              input logic sp, input logic md, input logic [15:0] cn);
    vec_t v;
    v.rst = r; v.key = k; v.sw = s; v.cyc = c;
    v.lvl = l; v.pr = p; v.rl = q; v.sp = sp; v.md = md; v.cnt = cn;
    tv.push_back(v);
  endfunction

  initial begin
    int b_step, b_p3, b_r3, b_p1, b_r1;
    logic [29:0] expv;

    //   rst key   sw cyc lvl   pr    rl    sp md cnt
    add(1, 4'hF, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'hE, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'hE, 0, 1, 4'h1, 4'h1, 4'h0, 0, 0, 16'd0);
    add(0, 4'hE, 0, 1, 4'h1, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'hF, 0, 5, 4'h1, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'hF, 0, 1, 4'h0, 4'h0, 4'h1, 0, 0, 16'd0);
    add(0, 4'hF, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'h7, 0, 5, 4'h0, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'h7, 0, 1, 4'h8, 4'h8, 4'h0, 0, 0, 16'd0);
    add(0, 4'h7, 0, 1, 4'h8, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'hF, 0, 6, 4'h0, 4'h0, 4'h8, 0, 0, 16'd0);
    add(0, 4'hF, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'h0, 0, 6, 4'hF, 4'hF, 4'h0, 0, 0, 16'd0);
    add(0, 4'h0, 0, 1, 4'hF, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'hF, 0, 6, 4'h0, 4'h0, 4'hF, 0, 0, 16'd0);
    add(0, 4'hF, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'h5, 0, 6, 4'hA, 4'hA, 4'h0, 0, 0, 16'd0);
    add(0, 4'h6, 0, 6, 4'h9, 4'h1, 4'h2, 0, 0, 16'd0);
    add(0, 4'h6, 0, 1, 4'h9, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'h6, 1, 1, 4'h9, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'h6, 1, 1, 4'h9, 4'h0, 4'h0, 0, 1, 16'd0);
    add(0, 4'h6, 0, 2, 4'h9, 4'h0, 4'h0, 0, 0, 16'd0);
    add(0, 4'hF, 0, 6, 4'h0, 4'h0, 4'h9, 0, 0, 16'd0);
    add(0, 4'hF, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'd0);

    rst = 1'b1; io.KEY = 4'hF; io.manual_sw = 1'b0;
    tick(2);

    foreach (tv[i]) begin
      rst = tv[i].rst; io.KEY = tv[i].key; io.manual_sw = tv[i].sw;
      tick(tv[i].cyc);
      expv = {tv[i].lvl, tv[i].pr, tv[i].rl, tv[i].sp, tv[i].md, tv[i].cnt};
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(expv));
    end

    // short low pulses on KEY[0] never survive the debounce window
    for (int r = 0; r < 5; r++) begin
      io.KEY = 4'hE;
      for (int c = 0; c < 3; c++) begin
        tick(1);
        chk($sformatf("glitch_lo%0d_%0d", r, c), 64'({io.key_level, io.key_press, io.key_release}), 64'd0);
      end
      io.KEY = 4'hF;
      tick(3);
      chk($sformatf("glitch_hi%0d", r), 64'({io.key_level, io.key_press, io.key_release}), 64'd0);
    end
    tick(8);
    chk("glitch_settle", 64'({io.key_level, io.key_press, io.key_release}), 64'd0);

    // three clean presses of KEY[3] in manual mode
    io.manual_sw = 1'b1;
    tick(3);
    chk("mode_on", 64'(io.manual_mode), 64'd1);
    b_step = mon_step; b_p3 = mon_p3; b_r3 = mon_r3;
    for (int r = 0; r < 3; r++) begin
      io.KEY = 4'h7; tick(8);
      io.KEY = 4'hF; tick(8);
    end
    chk("step_pulses", 64'(mon_step - b_step), 64'd3);
    chk("step_press3", 64'(mon_p3 - b_p3), 64'd3);
    chk("step_rel3",   64'(mon_r3 - b_r3), 64'd3);
    chk("step_count",  64'(io.step_count), 64'd3);

    // wrap: hold the counter at its maximum and take one step
    force dut.step_count_q = 16'hFFFF;
    io.KEY = 4'h7;
    tick(4);
    chk("wrap_pre_q", 64'(io.step_count), 64'hFFFF);
    chk("wrap_pre_d", 64'(dut.step_count_d), 64'hFFFF);
    tick(1);
    chk("wrap_next", 64'(dut.step_count_d), 64'h0000);
    tick(1);
    chk("wrap_pulse", 64'(io.step_pulse), 64'd1);
    release dut.step_count_q;
    io.KEY = 4'hF;
    rst = 1'b1; tick(2);
    chk("wrap_reset", 64'(outs()), 64'd0);
    rst = 1'b0;

    // reset in the middle of a KEY[1] debounce, key held throughout
    io.manual_sw = 1'b1;
    tick(3);
    io.KEY = 4'hD;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_a", 64'(outs()), 64'd0);
    tick(1);
    chk("mid_rst_b", 64'(outs()), 64'd0);
    b_p1 = mon_p1; b_r1 = mon_r1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      chk($sformatf("post_rst_%0d", c), 64'({io.key_level, io.key_press}), 64'd0);
    end
    tick(1);
    chk("post_rst_press", 64'({io.key_level, io.key_press}), 64'({4'h2, 4'h2}));
    tick(2);
    chk("post_rst_p1", 64'(mon_p1 - b_p1), 64'd1);
    chk("post_rst_r1", 64'(mon_r1 - b_r1), 64'd0);
    chk("post_rst_mode", 64'(io.manual_mode), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_step_ctrl.md
KEY_STEP_CTRL -- requirements
Module: key_step_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, is the number of consecutive stable cycles needed to accept a key change (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 CLOCK_50  input  1  the single clock for the whole block; all flops are rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on CLOCK_50.
REQ-004 KEY  input  4  raw board pushbuttons, active-low, asynchronous and bouncing.
REQ-005 manual_sw  input  1  raw slide switch, asynchronous; 1 selects single-step mode.
REQ-006 key_level  output  4  debounced key state, active-high (1 = pressed).
REQ-007 key_press  output  4  one-cycle pulse per key on each accepted press.
REQ-008 key_release  output  4  one-cycle pulse per key on each accepted release.
REQ-009 manual_mode  output  1  synchronized manual_sw.
REQ-010 step_pulse  output  1  one-cycle single-step request for the CPU clock generator.
REQ-011 step_count  output  16  number of step_pulse events since reset.

Function
REQ-012 Each KEY bit SHALL be inverted and passed through a 2-flop synchronizer; the second flop output is sync[i].
REQ-013 manual_sw SHALL pass through its own 2-flop synchronizer; manual_mode is the second flop output.
REQ-014 Each key SHALL have an independent counter, cnt[i], that is 20 bits wide.
REQ-015 cnt[i] behaviour on each cycle:
- When sync[i] equals key_level[i], cnt[i] SHALL clear to 0.
- Otherwise cnt[i] SHALL increment by 1.
REQ-016 When sync[i] differs from key_level[i] and cnt[i] equals DEB_CYCLES-1, the next edge SHALL do the following:
- toggle key_level[i];
- clear cnt[i].
REQ-017 A glitch that is shorter than DEB_CYCLES cycles at sync[i] SHALL clear cnt[i] and SHALL NOT change key_level[i].
REQ-018 Latency from a stable raw KEY change to the key_level change SHALL be exactly 2+DEB_CYCLES cycles.
REQ-019 key_press[i] SHALL be high in exactly the cycle where key_level[i] is 1 and its previous-cycle value was 0, and low otherwise.
REQ-020 key_release[i] SHALL be high in exactly the cycle where key_level[i] is 0 and its previous-cycle value was 1, and low otherwise.
REQ-021 Per-key state machine, one instance per key:
- RELEASED -> (sync=1) -> ARMING_PRESS;
- ARMING_PRESS -> (sync=0) -> RELEASED;
- ARMING_PRESS -> (count reached) -> PRESSED, with press pulse;
- PRESSED -> (sync=0) -> ARMING_RELEASE;
- ARMING_RELEASE -> (sync=1) -> PRESSED;
- ARMING_RELEASE -> (count reached) -> RELEASED, with release pulse.
REQ-022 The four keys SHALL operate fully independently.
REQ-023 Simultaneous accepted changes on several keys SHALL pulse every affected key in the same cycle.
REQ-024 step_pulse SHALL equal key_press[3] AND manual_mode, and SHALL be registered in the same cycle as key_press[3].
REQ-025 When manual_mode is 0, step_pulse SHALL stay 0 and KEY[3] debounce SHALL continue normally.
REQ-026 step_count SHALL increment by 1 in each cycle that step_pulse is high, and SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-027 A manual_mode change SHALL NOT alter key_level, cnt or step_count.

Reset
REQ-028 While reset is high, the following SHALL be forced to 0 on every edge:
- synchronizer flops (the pressed-state view), key_level, cnt, key_press, key_release, manual_mode sync flops, step_pulse, step_count;
- all state machines to RELEASED.
REQ-029 Reset asserted mid-debounce SHALL discard partial counts and SHALL produce no pulse.
REQ-030 A key held through reset release SHALL be accepted as a new press 2+DEB_CYCLES cycles after reset deasserts.

Verification (DEB_CYCLES=4)
REQ-031 After reset, drive KEY=4'b1110 steady: key_level=4'b0001 exactly 6 cycles later, with a one-cycle key_press=4'b0001 in that same cycle.
REQ-032 Drive KEY[0] low for 3 cycles, then high, repeated 5 times: key_level[0] stays 0, and there is no key_press or key_release.
REQ-033 With manual_sw=1 held (synchronized), press and release KEY[3] 3 times cleanly: exactly 3 step_pulse, step_count=3, and 3 key_release[3].
REQ-034 With manual_sw=0, press KEY[3]: key_press[3] pulses, step_pulse stays 0, step_count stays 0.
REQ-035 Preload 65535 steps (or force step_count=16'hFFFF), then perform 1 step: step_count=16'h0000.
REQ-036 Assert reset 3 cycles into a KEY[1] press: all outputs are 0 during reset; with KEY[1] still low, key_press[1] fires 6 cycles after reset deasserts.
